// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-lane right shifter that two requesters share.
// The shift stage moves data right by 0..MAX_STEP lanes in one cycle and
// fills the vacated top lanes with the captured fill lane. Longer shifts
// run the stage over several cycles. Requests are arbitrated round-robin.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready                 request handshake (N = 0, 1)
//   reqN_data/amt/fill               operand, shift amount in lanes, fill lane
//   resp_valid/ready                 response handshake
//   resp_data/id/err                 result, owning requester, amt > LANES flag
//   busy                             high whenever the FSM is not IDLE

// Lane mux for one output lane: picks candidate[step]. The candidates
// are the input lanes i..i+MAX_STEP, with fill already substituted above
// the top lane.
module shift_right_seq_lane #(
  parameter int LANE_W   = 5,
  parameter int MAX_STEP = 4,
  parameter int AW       = 4
) (
  input  logic [MAX_STEP:0][LANE_W-1:0] cand,
  input  logic [AW-1:0]                 step,
  output logic [LANE_W-1:0]             lane
);
  always_comb begin
    lane = cand[0];
    for (int k = 1; k <= MAX_STEP; k++)
      if (step == AW'(k)) lane = cand[k];
  end
endmodule

module shift_right_seq #(
  parameter  int LANES    = 10,
  parameter  int LANE_W   = 5,
  parameter  int MAX_STEP = 4,
  parameter  int AW       = 4,
  localparam int DW       = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DW-1:0]     req0_data,
  input  logic [AW-1:0]     req0_amt,
  input  logic [LANE_W-1:0] req0_fill,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DW-1:0]     req1_data,
  input  logic [AW-1:0]     req1_amt,
  input  logic [LANE_W-1:0] req1_fill,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DW-1:0]     resp_data,
  output logic              resp_id,
  output logic              resp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef struct packed {
    logic [LANES-1:0][LANE_W-1:0] data;
    logic [AW-1:0]                amt;
    logic [LANE_W-1:0]            fill;
  } req_t;

  state_t                       state, nxt;
  logic                         rr_ptr, granted_any;
  logic [AW-1:0]                rem, step;
  logic [LANES-1:0][LANE_W-1:0] data_q, shifted;
  logic [LANE_W-1:0]            fill_q;
  logic                         id_q, err_q;
  logic                         gnt_id, take;
  req_t                         sel;

  // Arbitration. rr_ptr resets to 0, yet req0 must win the first tie, so
  // alternation only starts once something has actually been granted.
  // rst_n gates take so no ready leaks out while reset is held.
  always_comb begin
    if (req0_valid && req1_valid) gnt_id = granted_any ? ~rr_ptr : 1'b0;
    else                          gnt_id = req1_valid;
    take = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    sel  = gnt_id ? req_t'{req1_data, req1_amt, req1_fill}
                  : req_t'{req0_data, req0_amt, req0_fill};
  end

  // Step never exceeds rem, so rem - step cannot underflow.
  always_comb step = (rem > AW'(MAX_STEP)) ? AW'(MAX_STEP) : rem;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_STEP:0][LANE_W-1:0] cand;
    for (genvar k = 0; k <= MAX_STEP; k++) begin : g_cand
      if (i + k < LANES) begin : g_in
        assign cand[k] = data_q[i+k];
      end else begin : g_fill
        assign cand[k] = fill_q;
      end
    end
    shift_right_seq_lane #(.LANE_W(LANE_W), .MAX_STEP(MAX_STEP), .AW(AW)) u_lane (
      .cand (cand),
      .step (step),
      .lane (shifted[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (take) nxt = (sel.amt == '0 || sel.amt > AW'(LANES)) ? DONE : SHIFT;
      SHIFT: if (rem == step) nxt = DONE;
      DONE:  if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
    resp_data  = data_q;
    resp_id    = id_q;
    resp_err   = err_q;
    req0_ready = take && !gnt_id;
    req1_ready = take &&  gnt_id;
  end

  // Datapath. Nothing changes in DONE, which keeps the response stable
  // under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 1'b0;
      granted_any <= 1'b0;
      rem         <= '0;
      data_q      <= '0;
      fill_q      <= '0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
    end else if (take) begin
      rr_ptr      <= gnt_id;
      granted_any <= 1'b1;
      id_q        <= gnt_id;
      fill_q      <= sel.fill;
      if (sel.amt > AW'(LANES)) begin
        data_q <= {LANES{sel.fill}};
        err_q  <= 1'b1;
        rem    <= '0;
      end else begin
        data_q <= sel.data;
        err_q  <= 1'b0;
        rem    <= sel.amt;
      end
    end else if (state == SHIFT) begin
      data_q <= shifted;
      rem    <= rem - step;
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;
  localparam logic [49:0] D_INC = {5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, resp_ready = 1;
  logic        req0_ready, req1_ready;
  logic [49:0] req0_data = '0, req1_data = '0;
  logic [3:0]  req0_amt = '0, req1_amt = '0;
  logic [4:0]  req0_fill = '0, req1_fill = '0;
  logic        resp_valid, resp_id, resp_err, busy;
  logic [49:0] resp_data;
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  shift_right_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_fill(req0_fill),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_fill(req1_fill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its grant, then its response (resp_ready=1).
  // lat counts edges from the edge preceding the grant to resp_valid.
  task automatic do_req(input string tag, input bit p, input logic [49:0] d,
                        input logic [3:0] a, input logic [4:0] f, input int exp_lat,
                        input logic [49:0] exp_d, input logic exp_err);
    int n;
    logic rdy;
    @(negedge clk);
    if (!p) begin req0_valid = 1; req0_data = d; req0_amt = a; req0_fill = f; end
    else    begin req1_valid = 1; req1_data = d; req1_amt = a; req1_fill = f; end
    #1;
    n = 0;
    rdy = p ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = p ? req1_ready : req0_ready;
    end
    chk({tag, "_rdy"}, rdy, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_data"}, resp_data, exp_d);
    chk({tag, "_id"}, resp_id, p);
    chk({tag, "_err"}, resp_err, exp_err);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n, viol, ord_viol, quiet;
    logic [49:0] hd;
    logic        hid;
    int          g[$], r[$];

    // Reset state, with both requesters already asserting valid
    req0_valid = 1; req1_valid = 1;
    #2;
    chk("rst_out", {resp_valid, resp_id, resp_err, busy, req0_ready, req1_ready}, 6'b0);
    chk("rst_data", resp_data, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst_n = 1;

    do_req("sh3",    0, D_INC, 4'd3, 5'h1F, 2,
           {5'h1F,5'h1F,5'h1F,5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3}, 0);
    do_req("sh10",   1, D_INC, 4'd10, 5'h0A, 4, {10{5'h0A}}, 0);
    do_req("sh0",    0, 50'h3_1234_5678_9ABC, 4'd0, 5'h1F, 1, 50'h3_1234_5678_9ABC, 0);
    do_req("sh12",   1, D_INC, 4'd12, 5'h03, 1, {10{5'h03}}, 1);
    do_req("sh5",    0, D_INC, 4'd5, 5'h00, 3,
           {5'h00,5'h00,5'h00,5'h00,5'h00,5'd9,5'd8,5'd7,5'd6,5'd5}, 0);

    // Backpressure: response held 5 cycles while req0 keeps asking
    resp_ready = 0;
    @(negedge clk);
    req1_valid = 1; req1_data = D_INC; req1_amt = 4'd2; req1_fill = 5'h11;
    #1; chk("bp_rdy", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_data = D_INC; req0_amt = 4'd1; req0_fill = 5'h00;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_lat", n, 1);
    chk("bp_data", resp_data, {5'h11,5'h11,5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2});
    hd = resp_data; hid = resp_id;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_data !== hd || resp_id !== hid || req0_ready || req1_ready) viol++;
    end
    chk("bp_hold", viol, 0);
    resp_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {resp_valid, busy, req0_ready}, 3'b001);
    req0_valid = 0;
    @(posedge clk); #1;

    // Reset during an amt=9 shift
    @(negedge clk);
    req0_valid = 1; req0_data = D_INC; req0_amt = 4'd9; req0_fill = 5'h15;
    #1; chk("mid_rdy", req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0;
    @(posedge clk); #1; chk("mid_busy", busy, 1);
    #1; rst_n = 0; req0_valid = 1; req1_valid = 1;
    #1;
    chk("mid_rst_out", {resp_valid, resp_id, resp_err, busy, req0_ready, req1_ready}, 6'b0);
    chk("mid_rst_data", resp_data, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst_n = 1;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (resp_valid || busy) quiet++;
    end
    chk("mid_quiet", quiet, 0);

    // Arbitration: both held valid, resp_ready=1
    req0_data = D_INC; req0_amt = 4'd1; req0_fill = 5'h01;
    req1_data = D_INC; req1_amt = 4'd1; req1_fill = 5'h02;
    req0_valid = 1; req1_valid = 1;
    viol = 0; ord_viol = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        if (busy || (req0_ready && req1_ready)) viol++;
        if (g.size() != r.size()) ord_viol++;
        g.push_back(req1_ready ? 1 : 0);
      end
      if (resp_valid && resp_ready) r.push_back(int'(resp_id));
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    chk("arb_cnt", g.size() >= 4, 1);
    chk("arb_g", {g[0][0], g[1][0], g[2][0], g[3][0]}, 4'b0101);
    chk("arb_resp", {r[0][0], r[1][0], r[2][0], r[3][0]}, 4'b0101);
    chk("arb_ready_viol", viol, 0);
    chk("arb_order", ord_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
